// File: rtl/gf2m_pkg.sv
// Shared defaults and FSM encoding for the GF(2^m) Itoh-Tsujii inverter.
package gf2m_pkg;

  // Default field: f(x) = x^101 + x^7 + x^6 + x + 1
  localparam int WIDTH_DEF = 101;
  localparam int K3_DEF    = 7;
  localparam int K2_DEF    = 6;
  localparam int K1_DEF    = 1;

  // Index of the most significant set bit of a positive integer
  function automatic int msb_idx(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Exponent of the addition chain (E = m-1) and its leading bit
  localparam int E_DEF     = WIDTH_DEF - 1;
  localparam int E_MSB_DEF = msb_idx(E_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DBL_SQR,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_ADD_SQR,
    S_FIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/gf2m_sqr.sv
// Combinational squaring in GF(2^WIDTH) modulo a pentanomial.
// Port bit w holds the coefficient of x^(WIDTH-1-w).
module gf2m_sqr #(
  parameter int WIDTH = 101,
  parameter int k3    = 7,
  parameter int k2    = 6,
  parameter int k1    = 1
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sq_o
);

  // Spread coefficients to even powers, then fold the high half down from
  // the top so terms created by the fold are themselves reduced.
  always_comb begin
    logic [2*WIDTH-2:0] s;
    s    = '0;
    sq_o = '0;
    for (int i = 0; i < WIDTH; i++) s[2*i] = a_i[WIDTH-1-i];
    for (int j = 2*WIDTH-2; j >= WIDTH; j--) begin
      s[j-WIDTH+k3] = s[j-WIDTH+k3] ^ s[j];
      s[j-WIDTH+k2] = s[j-WIDTH+k2] ^ s[j];
      s[j-WIDTH+k1] = s[j-WIDTH+k1] ^ s[j];
      s[j-WIDTH]    = s[j-WIDTH]    ^ s[j];
      s[j]          = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) sq_o[i] = s[WIDTH-1-i];
  end

endmodule

// File: rtl/gf2m_inv.sv
// Itoh-Tsujii inversion a^(2^m - 2): squarings done locally one per cycle,
// multiplications handed to an external digit-serial multiplier.
module gf2m_inv
  import gf2m_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int k3    = K3_DEF,
  parameter int k2    = K2_DEF,
  parameter int k1    = K1_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] op_c_o,
  output logic             mul_start_o,
  output logic [WIDTH-1:0] mul_op_a_o,
  output logic [WIDTH-1:0] mul_op_b_o,
  input  logic             mul_done_i,
  input  logic [WIDTH-1:0] mul_op_c_i
);

  localparam int KW    = $clog2(WIDTH);
  localparam int E     = WIDTH - 1;
  localparam int E_MSB = msb_idx(E);
  localparam logic [KW-1:0] E_VEC     = KW'(E);
  localparam logic [KW-1:0] BITP_INIT = KW'((E_MSB > 0) ? E_MSB - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_r_q, a_r_d;
  logic [WIDTH-1:0] beta_q, beta_d;      // a^(2^k - 1)
  logic [WIDTH-1:0] t_q, t_d;            // squaring scratch
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    sq_cnt_q, sq_cnt_d;
  logic [KW-1:0]    bitp_q, bitp_d;
  logic             add_q, add_d;        // pending multiply is an "add a" step
  logic [WIDTH-1:0] op_c_q, op_c_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;

  logic [WIDTH-1:0] sq_in, sq_out;
  logic [KW-1:0]    e_sh;

  // Single squarer: t while doubling, beta for the add step and final square
  assign sq_in = (state_q == S_DBL_SQR) ? t_q : beta_q;
  assign e_sh  = E_VEC >> bitp_q;

  gf2m_sqr #(
    .WIDTH(WIDTH),
    .k3   (k3),
    .k2   (k2),
    .k1   (k1)
  ) u_sqr (
    .a_i (sq_in),
    .sq_o(sq_out)
  );

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mul_start_o = (state_q == S_MUL_REQ);
  assign op_c_o      = op_c_q;
  assign mul_op_a_o  = mul_a_q;
  assign mul_op_b_o  = mul_b_q;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_r_q    <= '0;
      beta_q   <= '0;
      t_q      <= '0;
      k_q      <= '0;
      sq_cnt_q <= '0;
      bitp_q   <= '0;
      add_q    <= 1'b0;
      op_c_q   <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_r_q    <= a_r_d;
      beta_q   <= beta_d;
      t_q      <= t_d;
      k_q      <= k_d;
      sq_cnt_q <= sq_cnt_d;
      bitp_q   <= bitp_d;
      add_q    <= add_d;
      op_c_q   <= op_c_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // Addition-chain sequencing; every path is data-independent in length
  always_comb begin
    state_d  = state_q;
    a_r_d    = a_r_q;
    beta_d   = beta_q;
    t_d      = t_q;
    k_d      = k_q;
    sq_cnt_d = sq_cnt_q;
    bitp_d   = bitp_q;
    add_d    = add_q;
    op_c_d   = op_c_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        a_r_d    = op_a_i;
        beta_d   = op_a_i;
        t_d      = op_a_i;
        k_d      = KW'(1);
        sq_cnt_d = KW'(1);
        bitp_d   = BITP_INIT;
        add_d    = 1'b0;
        // E = 1 has no chain bits below its MSB: only the final square
        state_d  = (E_MSB == 0) ? S_FIN : S_DBL_SQR;
      end
      S_DBL_SQR: begin
        t_d      = sq_out;
        sq_cnt_d = sq_cnt_q - KW'(1);
        if (sq_cnt_q == KW'(1)) begin
          mul_a_d = sq_out;
          mul_b_d = beta_q;
          k_d     = k_q + k_q;
          add_d   = 1'b0;
          state_d = S_MUL_REQ;
        end
      end
      S_MUL_REQ: state_d = S_MUL_WAIT;
      S_MUL_WAIT: if (mul_done_i) begin
        beta_d = mul_op_c_i;
        if (!add_q && e_sh[0]) begin
          state_d = S_ADD_SQR;
        end else if (bitp_q == '0) begin
          state_d = S_FIN;
        end else begin
          bitp_d   = bitp_q - KW'(1);
          t_d      = mul_op_c_i;
          sq_cnt_d = k_q;
          state_d  = S_DBL_SQR;
        end
      end
      S_ADD_SQR: begin
        t_d     = sq_out;
        mul_a_d = sq_out;
        mul_b_d = a_r_q;
        k_d     = k_q + KW'(1);
        add_d   = 1'b1;
        state_d = S_MUL_REQ;
      end
      S_FIN: begin
        op_c_d  = sq_out;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gf2m_inv.sv
// Self-checking bench for gf2m_inv with a behavioural multiplier responder.
module tb_gf2m_inv;

  localparam int W  = 101;
  localparam int K3 = 7;
  localparam int K2 = 6;
  localparam int K1 = 1;
  localparam logic [W-1:0] ONE_P = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] X_P   = {2'b01, {(W-2){1'b0}}};

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] op_a;
  logic         busy, done, mul_start;
  logic [W-1:0] op_c, mul_op_a, mul_op_b;
  logic         mul_done = 1'b0;
  logic [W-1:0] mul_op_c = '0;

  int nvec = 0, nerr = 0;
  int mstart_cnt = 0, lat_acc = 0, stab_err = 0, dbl_err = 0;
  int lat_mode;
  bit spur;
  logic [W-1:0] last_c, xinv_p;

  gf2m_inv #(.WIDTH(W), .k3(K3), .k2(K2), .k1(K1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_a_i     (op_a),
    .busy_o     (busy),
    .done_o     (done),
    .op_c_o     (op_c),
    .mul_start_o(mul_start),
    .mul_op_a_o (mul_op_a),
    .mul_op_b_o (mul_op_b),
    .mul_done_i (mul_done),
    .mul_op_c_i (mul_op_c)
  );

  always #5 clk = ~clk;

  // ---- reference arithmetic (natural order: bit i = coefficient of x^i)
  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // multiply by x modulo f
  function automatic logic [W-1:0] xt(input logic [W-1:0] v);
    logic [W-1:0] f, r;
    f = '0; f[0] = 1'b1; f[K1] = 1'b1; f[K2] = 1'b1; f[K3] = 1'b1;
    r = v << 1;
    if (v[W-1]) r = r ^ f;
    return r;
  endfunction

  // Horner-style shift-and-add multiplication mod f
  function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W-1; i >= 0; i--) begin
      r = xt(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gmul_p(input logic [W-1:0] a, input logic [W-1:0] b);
    return rev(gmul(rev(a), rev(b)));
  endfunction

  // a^(2^W - 2) = product of a^(2^i) for i = 1..W-1 (port ordering in/out)
  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] ap);
    logic [W-1:0] s, r;
    s = rev(ap);
    r = W'(1);
    for (int i = 1; i < W; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return rev(r);
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_nz();
    logic [W-1:0] v;
    v = rnd_w();
    while (v == '0) v = rnd_w();
    return v;
  endfunction

  // ---- multiplier responder: latency 7, or 1..20 when lat_mode is set
  always @(posedge clk) begin
    bit fire;
    int l;
    logic [W-1:0] la, lb, prod;
    int rem;
    bit pend;
    fire = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (mul_op_a !== la || mul_op_b !== lb) stab_err++;
      if (mul_start) dbl_err++;
      rem--;
      if (rem == 0) begin fire = 1'b1; pend = 1'b0; end
    end else if (mul_start) begin
      mstart_cnt++;
      l = (lat_mode != 0) ? int'($urandom_range(20, 1)) : 7;
      lat_acc += l;
      la = mul_op_a;
      lb = mul_op_b;
      prod = gmul_p(la, lb);
      if (l == 1) fire = 1'b1;
      else begin rem = l - 1; pend = 1'b1; end
    end
    #1;
    mul_done = fire | spur;
    mul_op_c = fire ? prod : rnd_w();
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; start is raised immediately.
  task automatic run_inv(input logic [W-1:0] a, input int pulse_at, input logic [W-1:0] pval,
                         output int lat, output logic [W-1:0] c, output int nm, output int ls);
    int m0, l0, s0, d0;
    bit hit;
    m0 = mstart_cnt; l0 = lat_acc; s0 = stab_err; d0 = dbl_err;
    op_a = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    chk("busy_after_start", W'(busy), W'(1));
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin hit = 1'b1; break; end
      @(negedge clk);
      lat++;
      start = (lat == pulse_at);
      if (start) op_a = pval;
    end
    start = 1'b0;
    chk("done_timeout", W'(hit), W'(1));
    chk("busy_at_done", W'(busy), W'(1));
    c  = op_c;
    nm = mstart_cnt - m0;
    ls = lat_acc - l0;
    @(negedge clk);
    chk("done_single_cycle", W'(done), W'(0));
    chk("busy_after_done", W'(busy), W'(0));
    chk("mul_ops_stable", W'(stab_err - s0), W'(0));
    chk("mul_start_overlap", W'(dbl_err - d0), W'(0));
  endtask

  task automatic inv_check(input string tag, input logic [W-1:0] a, input int pulse_at,
                           input logic [W-1:0] pval);
    int lat, nm, ls;
    logic [W-1:0] c, exp;
    exp = ref_inv(a);
    run_inv(a, pulse_at, pval, lat, c, nm, ls);
    chk({tag, "_result"}, c, exp);
    chk({tag, "_op_c_hold"}, op_c, exp);
    if (a != '0) chk({tag, "_a_times_c"}, gmul_p(a, c), ONE_P);
    chk({tag, "_mul_count"}, W'(nm), W'(8));
    chk({tag, "_latency"}, W'(lat), W'(2 + 100 + 8 + ls));
    last_c = c;
  endtask

  initial begin
    logic [W-1:0] a;
    bit found;
    rst = 1'b1; start = 1'b0; op_a = '0; spur = 1'b0; lat_mode = 0;
    xinv_p = '0; xinv_p[0] = 1'b1; xinv_p[94] = 1'b1; xinv_p[95] = 1'b1; xinv_p[100] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_mul_start", W'(mul_start), W'(0));
    chk("rst_op_c", op_c, '0);
    chk("rst_mul_op_a", mul_op_a, '0);
    chk("rst_mul_op_b", mul_op_b, '0);
    rst = 1'b0;
    @(negedge clk);

    inv_check("one", ONE_P, 0, '0);
    chk("one_const", last_c, ONE_P);
    inv_check("zero", '0, 0, '0);
    chk("zero_const", last_c, '0);
    inv_check("x", X_P, 0, '0);
    chk("x_const", last_c, xinv_p);

    // stray mul_done while idle must not disturb anything
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_busy", W'(busy), W'(0));
    chk("stray_done_op_c", op_c, xinv_p);

    // second start in the middle of an inversion
    inv_check("restart", rnd_nz(), 11, rnd_nz());

    // reset while waiting on the multiplier, then a fresh inversion
    a = rnd_nz();
    op_a = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mul_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("mid_rst_mul_seen", W'(found), W'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_done", W'(done), W'(0));
    chk("mid_rst_mul_start", W'(mul_start), W'(0));
    chk("mid_rst_op_c", op_c, '0);
    chk("mid_rst_mul_op_a", mul_op_a, '0);
    chk("mid_rst_mul_op_b", mul_op_b, '0);
    rst = 1'b0;
    inv_check("after_rst", X_P, 0, '0);
    chk("after_rst_const", last_c, xinv_p);

    for (int n = 0; n < 200; n++) inv_check("rand", rnd_nz(), 0, '0);

    lat_mode = 1;
    for (int n = 0; n < 40; n++) inv_check("varlat", rnd_nz(), 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
